// File: rtl/pattern_buffer_bank_pkg.sv
// Shared constants for the pattern buffer bank: serial frame layout, rw/space encodings
// and the location of the seq_last register in sequence space.
package pattern_buf_pkg;

  // Bit positions within a frame, counted from the first bit shifted in.
  localparam int unsigned FrmRwOfs    = 0;
  localparam int unsigned FrmSpaceOfs = 1;
  localparam int unsigned FrmAddrOfs  = 2;

  typedef enum logic {
    RwRead  = 1'b0,
    RwWrite = 1'b1
  } rw_e;

  typedef enum logic {
    SpaceMem = 1'b0,
    SpaceSeq = 1'b1
  } space_e;

  // seq_last sits directly after the last sequence table entry.
  localparam int unsigned SeqLastOfs = 0;

  function automatic int unsigned frame_len(int unsigned a_w, int unsigned data_w);
    return FrmAddrOfs + a_w + data_w;
  endfunction

  function automatic int unsigned seq_last_idx(int unsigned seq_len);
    return seq_len + SeqLastOfs;
  endfunction

endpackage

// File: rtl/pattern_buffer_bank_serial_frame_rx.sv
// Serial frame receiver: counts and shifts frame bits, decodes address/data, raises the write
// strobe on the final bit and shifts read data out on o_sout.
module serial_frame_rx
  import pattern_buf_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned A_W    = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_ssel,
  input  logic              i_sin,
  output logic              o_sout,
  output logic              o_we,
  output space_e            o_space,
  output logic [A_W-1:0]    o_addr,
  output logic [DATA_W-1:0] o_wdata,
  output space_e            o_rd_space,
  output logic [A_W-1:0]    o_rd_addr,
  input  logic [DATA_W-1:0] i_rdata
);

  localparam int unsigned F      = frame_len(A_W, DATA_W);
  localparam int unsigned HdrLen = FrmAddrOfs + A_W;
  localparam int unsigned CntW   = $clog2(F + 1);
  localparam int unsigned LeftW  = $clog2(DATA_W + 1);

  logic [CntW-1:0]   r_cnt;
  logic [F-2:0]      r_shift;
  logic [F-1:0]      w_frame;
  logic              w_active;
  logic              w_rd_load;
  rw_e               w_rw_hdr;
  rw_e               w_rw_full;
  logic              r_sout;
  logic [DATA_W-1:0] r_rd_sh;
  logic [LeftW-1:0]  r_rd_left;

  // Bits already shifted plus the one being sampled on this edge.
  assign w_frame   = {r_shift, i_sin};
  assign w_active  = i_ssel && (r_cnt < CntW'(F));
  assign w_rw_hdr  = rw_e'(w_frame[HdrLen-1-FrmRwOfs]);
  assign w_rw_full = rw_e'(w_frame[F-1-FrmRwOfs]);

  assign o_rd_space = space_e'(w_frame[HdrLen-1-FrmSpaceOfs]);
  assign o_rd_addr  = w_frame[A_W-1:0];
  assign w_rd_load  = i_ssel && (r_cnt == CntW'(HdrLen - 1)) && (w_rw_hdr == RwRead);

  assign o_space = space_e'(w_frame[F-1-FrmSpaceOfs]);
  assign o_addr  = w_frame[DATA_W +: A_W];
  assign o_wdata = w_frame[DATA_W-1:0];
  assign o_we    = i_ssel && (r_cnt == CntW'(F - 1)) && (w_rw_full == RwWrite);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_shift <= '0;
    end else if (!i_ssel) begin
      r_cnt <= '0;
    end else if (w_active) begin
      r_cnt   <= r_cnt + 1'b1;
      r_shift <= w_frame[F-2:0];
    end
  end

  // Read data is launched on the edge that completes the address.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sout    <= 1'b0;
      r_rd_sh   <= '0;
      r_rd_left <= '0;
    end else if (!i_ssel) begin
      r_sout    <= 1'b0;
      r_rd_left <= '0;
    end else if (w_rd_load) begin
      r_sout    <= i_rdata[DATA_W-1];
      r_rd_sh   <= i_rdata << 1;
      r_rd_left <= LeftW'(DATA_W - 1);
    end else if (r_rd_left != '0) begin
      r_sout    <= r_rd_sh[DATA_W-1];
      r_rd_sh   <= r_rd_sh << 1;
      r_rd_left <= r_rd_left - 1'b1;
    end else begin
      r_sout <= 1'b0;
    end
  end

  assign o_sout = r_sout;

endmodule

// File: rtl/pattern_buffer_bank.sv
// Multi-buffer pattern store: serially loaded/read buffer memory and sequence table, with a
// stepped playback pointer selecting one registered byte per cycle.
module pattern_buffer_bank
  import pattern_buf_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned NUM_BUFS = 8,
  parameter int unsigned FIELDS   = 32,
  parameter int unsigned SEQ_LEN  = 3,
  localparam int unsigned BUF_W   = $clog2(NUM_BUFS),
  localparam int unsigned FIELD_W = $clog2(FIELDS),
  localparam int unsigned SEQ_W   = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1
) (
  input  logic               sclk,
  input  logic               rst_n,
  input  logic               ssel,
  input  logic               sin,
  output logic               sout,
  input  logic               step,
  input  logic               sync_clear,
  output logic [DATA_W-1:0]  field_byte,
  output logic [BUF_W-1:0]   cur_buf,
  output logic [FIELD_W-1:0] field_ptr,
  output logic [SEQ_W-1:0]   seq_idx,
  output logic               wrap
);

  localparam int unsigned A_W   = BUF_W + FIELD_W;
  localparam int unsigned Depth = NUM_BUFS * FIELDS;

  logic              w_we;
  space_e            w_space;
  logic [A_W-1:0]    w_addr;
  logic [DATA_W-1:0] w_wdata;
  space_e            w_rd_space;
  logic [A_W-1:0]    w_rd_addr;
  logic [DATA_W-1:0] w_rdata;
  logic              w_sout;

  logic [DATA_W-1:0]  r_mem [Depth];
  logic [BUF_W-1:0]   r_seq [SEQ_LEN];
  logic [SEQ_W-1:0]   r_seq_last;
  logic [FIELD_W-1:0] r_field_ptr;
  logic [SEQ_W-1:0]   r_seq_idx;
  logic               r_wrap;
  logic [DATA_W-1:0]  r_field_byte;
  logic [BUF_W-1:0]   w_cur_buf;

  serial_frame_rx #(
    .DATA_W (DATA_W),
    .A_W    (A_W)
  ) u_rx (
    .i_clk      (sclk),
    .i_rst_n    (rst_n),
    .i_ssel     (ssel),
    .i_sin      (sin),
    .o_sout     (w_sout),
    .o_we       (w_we),
    .o_space    (w_space),
    .o_addr     (w_addr),
    .o_wdata    (w_wdata),
    .o_rd_space (w_rd_space),
    .o_rd_addr  (w_rd_addr),
    .i_rdata    (w_rdata)
  );

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) r_mem[i] <= '0;
    end else if (w_we && (w_space == SpaceMem)) begin
      r_mem[w_addr] <= w_wdata;
    end
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SEQ_LEN; i++) r_seq[i] <= BUF_W'(i % NUM_BUFS);
      r_seq_last <= SEQ_W'(SEQ_LEN - 1);
    end else if (w_we && (w_space == SpaceSeq)) begin
      for (int i = 0; i < SEQ_LEN; i++) begin
        if (w_addr == A_W'(i)) r_seq[i] <= w_wdata[BUF_W-1:0];
      end
      if (w_addr == A_W'(seq_last_idx(SEQ_LEN))) begin
        r_seq_last <= (w_wdata > DATA_W'(SEQ_LEN - 1)) ? SEQ_W'(SEQ_LEN - 1)
                                                       : w_wdata[SEQ_W-1:0];
      end
    end
  end

  // Serial readback; unmapped sequence-space indices read as zero.
  always_comb begin
    w_rdata = '0;
    if (w_rd_space == SpaceMem) begin
      w_rdata = r_mem[w_rd_addr];
    end else begin
      for (int i = 0; i < SEQ_LEN; i++) begin
        if (w_rd_addr == A_W'(i)) w_rdata = DATA_W'(r_seq[i]);
      end
      if (w_rd_addr == A_W'(seq_last_idx(SEQ_LEN))) w_rdata = DATA_W'(r_seq_last);
    end
  end

  always_comb begin
    w_cur_buf = '0;
    for (int i = 0; i < SEQ_LEN; i++) begin
      if (r_seq_idx == SEQ_W'(i)) w_cur_buf = r_seq[i];
    end
  end

  // A lowered seq_last is honoured by the >= compare at the next sequence advance.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_field_ptr <= '0;
      r_seq_idx   <= '0;
      r_wrap      <= 1'b0;
    end else if (sync_clear) begin
      r_field_ptr <= '0;
      r_seq_idx   <= '0;
      r_wrap      <= 1'b0;
    end else if (step) begin
      if (r_field_ptr == FIELD_W'(FIELDS - 1)) begin
        r_field_ptr <= '0;
        if (r_seq_idx >= r_seq_last) begin
          r_seq_idx <= '0;
          r_wrap    <= 1'b1;
        end else begin
          r_seq_idx <= r_seq_idx + 1'b1;
          r_wrap    <= 1'b0;
        end
      end else begin
        r_field_ptr <= r_field_ptr + 1'b1;
        r_wrap      <= 1'b0;
      end
    end else begin
      r_wrap <= 1'b0;
    end
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_field_byte <= '0;
    end else begin
      r_field_byte <= r_mem[{w_cur_buf, r_field_ptr}];
    end
  end

  assign sout       = w_sout;
  assign field_byte = r_field_byte;
  assign cur_buf    = w_cur_buf;
  assign field_ptr  = r_field_ptr;
  assign seq_idx    = r_seq_idx;
  assign wrap       = r_wrap;

endmodule
